// File: rtl/sram_port_ctrl.sv
// Request-to-pin controller for an external async SRAM (IDLE/SETUP/ACCESS/HOLD, all pins registered).
// Optional back-to-back mode: define SRAM_PORT_CTRL_B2B_EN to accept a new request during HOLD.
module sram_port_ctrl #(
    parameter int unsigned AW          = 12,
    parameter int unsigned DW          = 16,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          wr,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          ready,
    output logic [DW-1:0] rdata,
    output logic          rvalid,
    output logic [AW-1:0] MEM_ADDR,
    inout  wire  [DW-1:0] MEM_DATA,
    output logic          MEM_OE,
    output logic          MEM_WE
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        HOLD
    } state_t;

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    state_t        state;
    logic          wr_q;
    logic [3:0]    cnt;
    logic [DW-1:0] dout;
    logic          drive_en;
    logic          accept;

    // ready is only ever high in states that may take a request, so accept needs no state qualifier
    assign accept   = req && ready;
    assign MEM_DATA = drive_en ? dout : 'z;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ready    <= 1'b1;
            wr_q     <= 1'b0;
            cnt      <= '0;
            dout     <= '0;
            drive_en <= 1'b0;
            MEM_ADDR <= '0;
            MEM_OE   <= 1'b1;
            MEM_WE   <= 1'b1;
            rdata    <= '0;
            rvalid   <= 1'b0;
        end else begin
            rvalid <= 1'b0;
            if (accept) begin
                state    <= SETUP;
                ready    <= 1'b0;
                wr_q     <= wr;
                MEM_ADDR <= addr;
                dout     <= wdata;
                drive_en <= wr;
            end else begin
                case (state)
                    IDLE: ;
                    SETUP: begin
                        state  <= ACCESS;
                        cnt    <= WAIT_LD;
                        MEM_WE <= ~wr_q;
                        MEM_OE <= wr_q;
                    end
                    ACCESS: begin
                        if (cnt == 4'd0) begin
                            state  <= HOLD;
                            MEM_WE <= 1'b1;
                            MEM_OE <= 1'b1;
                            if (!wr_q) begin
                                rdata  <= MEM_DATA;
                                rvalid <= 1'b1;
                            end
`ifdef SRAM_PORT_CTRL_B2B_EN
                            ready <= 1'b1;
`else
                            ready <= 1'b0;
`endif
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                    HOLD: begin
                        state    <= IDLE;
                        ready    <= 1'b1;
                        drive_en <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Directed bench for sram_port_ctrl with a simple SRAM model on the shared data bus.
module tb_sram_port_ctrl;

`ifdef SRAM_PORT_CTRL_B2B_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, req, wr;
    logic [11:0] addr;
    logic [15:0] wdata;
    logic        ready, rvalid, MEM_OE, MEM_WE;
    logic [15:0] rdata;
    logic [11:0] MEM_ADDR;
    wire  [15:0] MEM_DATA;
    logic        tb_drv;

    logic [15:0] mem [0:4095];
    int unsigned we_lo = 0, oe_lo = 0, both_lo = 0, rv_cnt = 0, bad_w = 0;
    logic        chk_w = 1'b0;
    int unsigned n_cmp = 0, n_bad = 0, cyc = 0;

    sram_port_ctrl #(.AW(12), .DW(16), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
        .ready(ready), .rdata(rdata), .rvalid(rvalid),
        .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA), .MEM_OE(MEM_OE), .MEM_WE(MEM_WE)
    );

    always #5 clk = ~clk;

    // SRAM drives on OE low; a probe pattern shows whether anything else is on the bus.
    assign MEM_DATA = (!MEM_OE) ? mem[MEM_ADDR] : 'z;
    assign MEM_DATA = tb_drv ? 16'h5A5A : 'z;

    always @(negedge clk) begin
        if (!MEM_WE) begin
            mem[MEM_ADDR] = MEM_DATA;
            we_lo++;
            if (chk_w && (MEM_ADDR != 12'h0FF || MEM_DATA != 16'h1234)) bad_w++;
        end
        if (!MEM_OE) oe_lo++;
        if (!MEM_WE && !MEM_OE) both_lo++;
        if (rvalid) rv_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic probe_z(input string tag);
        tb_drv = 1'b1;
        #1;
        check_eq(tag, 32'(MEM_DATA), 32'h5A5A);
        tb_drv = 1'b0;
        #1;
    endtask

    int unsigned rv0, we0, oe0, bw0, n, nacc, last_acc;
    logic        pre;

    initial begin
        rst = 1'b1; req = 1'b0; wr = 1'b0; addr = '0; wdata = '0; tb_drv = 1'b0;
        step(); step();
        rst = 1'b0;
        check_eq("rst_ready", 32'(ready), 32'd1);
        check_eq("rst_we", 32'(MEM_WE), 32'd1);
        check_eq("rst_oe", 32'(MEM_OE), 32'd1);
        check_eq("rst_addr", 32'(MEM_ADDR), 32'h0);
        check_eq("rst_rdata", 32'(rdata), 32'h0);
        rv0 = rv_cnt;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("idle_ready", 32'(ready), 32'd1);
            probe_z("idle_z");
        end
        check_eq("idle_no_rvalid", rv_cnt - rv0, 32'd0);

        // write 005 <- A55A
        req = 1'b1; wr = 1'b1; addr = 12'h005; wdata = 16'hA55A;
        step();
        req = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        we0 = we_lo;
        check_eq("wr_setup_ready", 32'(ready), 32'd0);
        check_eq("wr_setup_addr", 32'(MEM_ADDR), 32'h005);
        check_eq("wr_setup_data", 32'(MEM_DATA), 32'hA55A);
        check_eq("wr_setup_we", 32'(MEM_WE), 32'd1);
        for (int i = 1; i <= 5; i++) begin
            step();
            check_eq("wr_we", 32'(MEM_WE), (i <= 3) ? 32'd0 : 32'd1);
            check_eq("wr_oe", 32'(MEM_OE), 32'd1);
            check_eq("wr_ready", 32'(ready), (i == 5 || (B2B && i == 4)) ? 32'd1 : 32'd0);
            if (i <= 4) begin
                check_eq("wr_data", 32'(MEM_DATA), 32'hA55A);
                check_eq("wr_addr", 32'(MEM_ADDR), 32'h005);
            end else begin
                probe_z("wr_done_z");
            end
        end
        check_eq("wr_we_cycles", we_lo - we0, 32'd3);
        check_eq("wr_no_rvalid", rv_cnt - rv0, 32'd0);
        check_eq("wr_mem", 32'(mem[12'h005]), 32'hA55A);

        // read 005
        req = 1'b1; wr = 1'b0; addr = 12'h005; wdata = 16'h0F0F;
        step();
        req = 1'b0;
        oe0 = oe_lo;
        check_eq("rd_setup_oe", 32'(MEM_OE), 32'd1);
        check_eq("rd_setup_addr", 32'(MEM_ADDR), 32'h005);
        probe_z("rd_setup_z");
        for (int i = 1; i <= 5; i++) begin
            step();
            check_eq("rd_oe", 32'(MEM_OE), (i <= 3) ? 32'd0 : 32'd1);
            check_eq("rd_we", 32'(MEM_WE), 32'd1);
            check_eq("rd_rvalid", 32'(rvalid), (i == 4) ? 32'd1 : 32'd0);
            check_eq("rd_ready", 32'(ready), (i == 5 || (B2B && i == 4)) ? 32'd1 : 32'd0);
            if (i == 4) check_eq("rd_rdata", 32'(rdata), 32'hA55A);
            if (i >= 4) probe_z("rd_tail_z");
        end
        check_eq("rd_oe_cycles", oe_lo - oe0, 32'd3);
        check_eq("rd_one_rvalid", rv_cnt - rv0, 32'd1);
        step(); step(); step();
        check_eq("rd_rdata_hold", 32'(rdata), 32'hA55A);
        check_eq("rd_rvalid_low", 32'(rvalid), 32'd0);

        // write 0FF <- 1234 while inputs churn and req pulses are ignored
        req = 1'b1; wr = 1'b1; addr = 12'h0FF; wdata = 16'h1234;
        chk_w = 1'b1;
        step();
        we0 = we_lo; bw0 = bad_w;
        for (int i = 0; i < 4; i++) begin
            req   = (i == 0 || i == 2);
            wr    = (i % 2 == 1);
            addr  = 12'h100 + 12'(i);
            wdata = 16'hDEAD ^ 16'(i);
            step();
        end
        req = 1'b0;
        step();
        check_eq("noisy_ready", 32'(ready), 32'd1);
        step(); step();
        check_eq("noisy_idle_ready", 32'(ready), 32'd1);
        check_eq("noisy_idle_we", 32'(MEM_WE), 32'd1);
        check_eq("noisy_we_cycles", we_lo - we0, 32'd3);
        check_eq("noisy_bad_writes", bad_w - bw0, 32'd0);
        check_eq("noisy_mem", 32'(mem[12'h0FF]), 32'h1234);
        chk_w = 1'b0;

        // write top address FFF <- C3C3
        req = 1'b1; wr = 1'b1; addr = 12'hFFF; wdata = 16'hC3C3;
        step();
        req = 1'b0;
        n = 0;
        while (!ready && n < 10) begin step(); n++; end
        check_eq("fff_wr_len", n, B2B ? 32'd4 : 32'd5);
        step();
        check_eq("fff_mem", 32'(mem[12'hFFF]), 32'hC3C3);

        // reset during ACCESS of a write
        req = 1'b1; wr = 1'b1; addr = 12'h0AA; wdata = 16'hBEEF;
        step();
        req = 1'b0;
        step();
        check_eq("abort_we_low", 32'(MEM_WE), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("abort_we", 32'(MEM_WE), 32'd1);
        check_eq("abort_oe", 32'(MEM_OE), 32'd1);
        check_eq("abort_ready", 32'(ready), 32'd1);
        check_eq("abort_addr", 32'(MEM_ADDR), 32'h0);
        check_eq("abort_rdata", 32'(rdata), 32'h0);
        probe_z("abort_z");

        // read FFF after the abort
        req = 1'b1; wr = 1'b0; addr = 12'hFFF;
        step();
        req = 1'b0;
        check_eq("fff_rd_addr", 32'(MEM_ADDR), 32'hFFF);
        n = 0;
        while (!rvalid && n < 10) begin step(); n++; end
        check_eq("fff_rd_lat", n, 32'd4);
        check_eq("fff_rd_rdata", 32'(rdata), 32'hC3C3);
        step();
        check_eq("fff_rd_ready", 32'(ready), 32'd1);

        // req held high across four writes
        req = 1'b1; wr = 1'b1; addr = 12'h001; wdata = 16'h1001;
        nacc = 0; last_acc = 0; n = 0;
        while (nacc < 4 && n < 60) begin
            pre = ready && req;
            step();
            n++;
            if (pre) begin
                nacc++;
                if (nacc > 1) check_eq("b2b_period", cyc - last_acc, B2B ? 32'd5 : 32'd6);
                last_acc = cyc;
                if (nacc < 4) begin
                    addr  = 12'(nacc + 1);
                    wdata = 16'h1000 + 16'(nacc + 1);
                end else begin
                    req = 1'b0;
                end
            end
        end
        check_eq("b2b_accepts", nacc, 32'd4);
        n = 0;
        while (!ready && n < 10) begin step(); n++; end
        check_eq("b2b_drained", 32'(ready), 32'd1);
        step();
        for (int i = 1; i <= 4; i++)
            check_eq("b2b_mem", 32'(mem[i]), 32'h1000 + 32'(i));
        check_eq("we_oe_never_both_low", both_lo, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
